// File: rtl/stereo_blend_pkg.sv
// rtl/stereo_blend_pkg.sv - shared types, gain constants and saturation helper for the stereo blend stage
package stereo_blend_pkg;

    typedef enum logic [1:0] {
        MONO      = 2'd0,
        RAMP_UP   = 2'd1,
        STEREO    = 2'd2,
        RAMP_DOWN = 2'd3
    } blend_state_e;

    localparam int GAIN_WIDTH_DEF = 8;
    localparam int GAIN_ONE       = 1 << GAIN_WIDTH_DEF;

    // Clamp v into the signed range of a w-bit two's-complement word.
    function automatic longint sat_clip(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/stereo_blend_if.sv
// rtl/stereo_blend_if.sv - sample/pilot inputs and blended outputs of the stereo blend stage
interface stereo_blend_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ERR_WIDTH  = 32,
    parameter int GAIN_WIDTH = 8
);
    logic signed [DATA_WIDTH-1:0] in_lpr;
    logic signed [DATA_WIDTH-1:0] in_lmr;
    logic                         in_valid;
    logic signed [ERR_WIDTH-1:0]  pilot_err;
    logic                         pilot_err_valid;
    logic                         force_mono;
    logic signed [DATA_WIDTH-1:0] out_left;
    logic signed [DATA_WIDTH-1:0] out_right;
    logic                         out_valid;
    logic                         stereo;
    logic [GAIN_WIDTH:0]          blend;

    modport master (
        output in_lpr, in_lmr, in_valid, pilot_err, pilot_err_valid, force_mono,
        input  out_left, out_right, out_valid, stereo, blend
    );

    modport slave (
        input  in_lpr, in_lmr, in_valid, pilot_err, pilot_err_valid, force_mono,
        output out_left, out_right, out_valid, stereo, blend
    );
endinterface

// File: rtl/pilot_lock_detect.sv
// rtl/pilot_lock_detect.sv - pilot PLL lock decision from consecutive good/bad loop-error samples
module pilot_lock_detect #(
    parameter int ERR_WIDTH    = 32,
    parameter int LOCK_THRESH  = 32'sd4096,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic signed [ERR_WIDTH-1:0] pilot_err,
    input  logic                        pilot_err_valid,
    output logic                        locked
);
    localparam int GCW = $clog2(LOCK_COUNT + 1);
    localparam int BCW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [GCW-1:0] GOOD_MAX = GCW'(LOCK_COUNT);
    localparam logic [BCW-1:0] BAD_MAX  = BCW'(UNLOCK_COUNT);

    logic [GCW-1:0] good_cnt_q, good_cnt_d;
    logic [BCW-1:0] bad_cnt_q, bad_cnt_d;
    logic           locked_q, locked_d;
    logic [ERR_WIDTH-1:0] mag;
    logic           good;

    always_comb begin
        // The most-negative error has no positive twin; pin it to the largest magnitude.
        if (pilot_err == {1'b1, {(ERR_WIDTH-1){1'b0}}})
            mag = {1'b0, {(ERR_WIDTH-1){1'b1}}};
        else if (pilot_err[ERR_WIDTH-1])
            mag = ERR_WIDTH'(-pilot_err);
        else
            mag = pilot_err;
        good = $signed({1'b0, mag}) < $signed((ERR_WIDTH+1)'(LOCK_THRESH));
    end

    always_comb begin
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        locked_d   = locked_q;
        if (pilot_err_valid) begin
            if (good) begin
                bad_cnt_d = '0;
                if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + 1'b1;
                if (good_cnt_d == GOOD_MAX) locked_d = 1'b1;
            end else begin
                good_cnt_d = '0;
                if (bad_cnt_q != BAD_MAX) bad_cnt_d = bad_cnt_q + 1'b1;
                if (bad_cnt_d == BAD_MAX) locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;
endmodule

// File: rtl/stereo_blend_ctrl.sv
// rtl/stereo_blend_ctrl.sv - click-free mono/stereo blend FSM and two-stage L/R matrix with saturation
module stereo_blend_ctrl
    import stereo_blend_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ERR_WIDTH    = 32,
    parameter int LOCK_THRESH  = 32'sd4096,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 16,
    parameter int GAIN_WIDTH   = GAIN_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    stereo_blend_if.slave bus
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 2;
    localparam logic [GAIN_WIDTH:0] UNITY = (GAIN_WIDTH+1)'(1 << GAIN_WIDTH);

    blend_state_e state_q, state_d;
    logic [GAIN_WIDTH:0] gain_q, gain_d, gain_up, gain_dn;
    logic locked, go_down;

    logic signed [PW-1:0]         prod_q, prod_d;
    logic signed [DATA_WIDTH-1:0] lpr_q, lpr_d;
    logic                         v1_q, v1_d;
    logic signed [DATA_WIDTH-1:0] out_left_q, out_left_d, out_right_q, out_right_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH:0]   s, sum_l, sum_r;

    pilot_lock_detect #(
        .ERR_WIDTH(ERR_WIDTH), .LOCK_THRESH(LOCK_THRESH),
        .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT)
    ) u_lock (
        .clk(clk), .reset_n(reset_n),
        .pilot_err(bus.pilot_err), .pilot_err_valid(bus.pilot_err_valid),
        .locked(locked)
    );

    // locked is registered, so a same-cycle pilot strobe cannot influence this step.
    assign go_down = bus.force_mono | ~locked;

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        gain_up = gain_q + 1'b1;
        gain_dn = gain_q - 1'b1;
        if (bus.in_valid) begin
            unique case (state_q)
                MONO: if (!go_down) begin
                    gain_d  = gain_up;
                    state_d = (gain_up == UNITY) ? STEREO : RAMP_UP;
                end
                RAMP_UP, RAMP_DOWN: if (go_down) begin
                    gain_d  = gain_dn;
                    state_d = (gain_dn == '0) ? MONO : RAMP_DOWN;
                end else begin
                    gain_d  = gain_up;
                    state_d = (gain_up == UNITY) ? STEREO : RAMP_UP;
                end
                STEREO: if (go_down) begin
                    gain_d  = gain_dn;
                    state_d = RAMP_DOWN;
                end
            endcase
        end
    end

    always_comb begin
        v1_d   = bus.in_valid;
        prod_d = bus.in_valid ? $signed(bus.in_lmr) * $signed({1'b0, gain_q}) : prod_q;
        lpr_d  = bus.in_valid ? bus.in_lpr : lpr_q;

        s     = (DATA_WIDTH+1)'(prod_q >>> GAIN_WIDTH);
        sum_l = $signed({lpr_q[DATA_WIDTH-1], lpr_q}) + s;
        sum_r = $signed({lpr_q[DATA_WIDTH-1], lpr_q}) - s;

        out_valid_d = v1_q;
        out_left_d  = v1_q ? DATA_WIDTH'(sat_clip(longint'(sum_l), DATA_WIDTH)) : out_left_q;
        out_right_d = v1_q ? DATA_WIDTH'(sat_clip(longint'(sum_r), DATA_WIDTH)) : out_right_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MONO;
            gain_q      <= '0;
            prod_q      <= '0;
            lpr_q       <= '0;
            v1_q        <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            prod_q      <= prod_d;
            lpr_q       <= lpr_d;
            v1_q        <= v1_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_left  = out_left_q;
    assign bus.out_right = out_right_q;
    assign bus.out_valid = out_valid_q;
    assign bus.stereo    = (state_q == STEREO);
    assign bus.blend     = gain_q;
endmodule

// File: tb/tb_stereo_blend_ctrl.sv
// tb/tb_stereo_blend_ctrl.sv - randomized self-checking bench for stereo_blend_ctrl against a behavioural model
module tb_stereo_blend_ctrl;
    import stereo_blend_pkg::*;

    localparam int DW = 16;
    localparam int EW = 32;
    localparam int GW = 8;
    localparam int THRESH = 4096;
    localparam int NLOCK = 64;
    localparam int NUNLOCK = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    stereo_blend_if #(.DATA_WIDTH(DW), .ERR_WIDTH(EW), .GAIN_WIDTH(GW)) bus ();

    stereo_blend_ctrl #(
        .DATA_WIDTH(DW), .ERR_WIDTH(EW), .LOCK_THRESH(THRESH),
        .LOCK_COUNT(NLOCK), .UNLOCK_COUNT(NUNLOCK), .GAIN_WIDTH(GW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_gain, m_good, m_bad;
    bit m_locked;
    bit p1_v, p2_v;
    int p1_l, p1_r, p2_l, p2_r;
    bit fm_lvl;
    longint edge_errs [6] = '{4095, -4095, 4096, -4096, -64'sd2147483648, 64'sd2147483647};

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int p, input int d);
        int q;
        q = p / d;
        if ((p % d != 0) && (p < 0)) q -= 1;
        return q;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_gain = 0; m_good = 0; m_bad = 0; m_locked = 0;
        p1_v = 0; p2_v = 0; p1_l = 0; p1_r = 0; p2_l = 0; p2_r = 0;
    endtask

    // One clock: drive, let the edge happen, advance the model, check on the falling edge.
    task automatic cycle(input bit iv, input int lpr, input int lmr, input bit pv, input longint pe);
        int sh;
        longint mag;
        bus.in_valid        = iv;
        bus.in_lpr          = DW'(lpr);
        bus.in_lmr          = DW'(lmr);
        bus.pilot_err_valid = pv;
        bus.pilot_err       = EW'(pe);
        bus.force_mono      = fm_lvl;
        @(posedge clk);
        p2_v = p1_v; p2_l = p1_l; p2_r = p1_r;
        p1_v = iv;
        if (iv) begin
            sh   = floor_div(lmr * m_gain, GAIN_ONE);
            p1_l = clamp16(lpr + sh);
            p1_r = clamp16(lpr - sh);
            if (fm_lvl || !m_locked) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
            else                     m_gain = (m_gain < GAIN_ONE) ? m_gain + 1 : GAIN_ONE;
        end
        if (pv) begin
            mag = (pe < 0) ? -pe : pe;
            if (mag < THRESH) begin
                m_bad = 0;
                if (m_good < NLOCK) m_good++;
                if (m_good == NLOCK) m_locked = 1;
            end else begin
                m_good = 0;
                if (m_bad < NUNLOCK) m_bad++;
                if (m_bad == NUNLOCK) m_locked = 0;
            end
        end
        @(negedge clk);
        check_val("out_valid", bus.out_valid, p2_v);
        if (p2_v) begin
            check_val("out_left", bus.out_left, p2_l);
            check_val("out_right", bus.out_right, p2_r);
        end
        check_val("blend", bus.blend, m_gain);
        check_val("stereo", bus.stereo, m_gain == GAIN_ONE);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic sample(input int lpr, input int lmr);
        cycle(1, lpr, lmr, 0, 0);
        idle(1);
    endtask

    task automatic pilot(input longint pe);
        cycle(0, 0, 0, 1, pe);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit last_iv;
        reset_n = 1'b0;
        fm_lvl = 0;
        bus.in_valid = 0; bus.in_lpr = '0; bus.in_lmr = '0;
        bus.pilot_err_valid = 0; bus.pilot_err = '0; bus.force_mono = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_left", bus.out_left, 0);
        check_val("rst_out_right", bus.out_right, 0);
        check_val("rst_stereo", bus.stereo, 0);
        check_val("rst_blend", bus.blend, 0);
        reset_n = 1'b1;

        // Unlocked pilot: pure mono passthrough of L+R.
        for (int i = 0; i < 20; i++) begin pilot(100000); sample(1000, 500); end
        check_val("mono_left", bus.out_left, 1000);

        // Lock, ramp fully up, one extra sample at unity gain.
        for (int i = 0; i < NLOCK; i++) pilot(0);
        for (int i = 0; i < GAIN_ONE + 1; i++) sample(1000, 500);
        check_val("unity_blend", bus.blend, GAIN_ONE);
        check_val("unity_left", bus.out_left, 1500);
        check_val("unity_right", bus.out_right, 500);

        // 15 bad then 1 good must not unlock; 16 bad must.
        for (int i = 0; i < NUNLOCK - 1; i++) pilot(100000);
        pilot(0);
        for (int i = 0; i < 4; i++) sample(1000, 500);
        check_val("hold_stereo", bus.stereo, 1);
        for (int i = 0; i < NUNLOCK; i++) pilot(-100000);
        for (int i = 0; i < GAIN_ONE; i++)
            sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        check_val("down_blend", bus.blend, 0);

        // force_mono reversal mid-ramp.
        for (int i = 0; i < NLOCK; i++) pilot(1);
        for (int i = 0; i < 100; i++) sample(2000, -700);
        check_val("ramp100", bus.blend, 100);
        fm_lvl = 1;
        sample(2000, -700);
        check_val("fm_first", bus.blend, 99);
        for (int i = 0; i < 49; i++) sample(-1234, 3333);
        check_val("fm_50", bus.blend, 50);
        fm_lvl = 0;
        sample(100, 100);
        check_val("resume51", bus.blend, 51);
        for (int i = 0; i < GAIN_ONE; i++) sample(100, 100);

        // Saturation at unity.
        sample(30000, 10000);
        check_val("sat_left_hi", bus.out_left, 32767);
        check_val("sat_right", bus.out_right, 20000);
        sample(-30000, 10000);
        check_val("sat_right_lo", bus.out_right, -32768);
        sample(32767, -32768);

        // Most-negative error must count as bad.
        for (int i = 0; i < NUNLOCK; i++) pilot(-64'sd2147483648);
        sample(0, 0);
        check_val("minerr_unlock", bus.blend, GAIN_ONE - 1);

        // Random traffic with coincident strobes and force_mono toggles.
        last_iv = 0;
        for (int i = 0; i < 3000; i++) begin
            bit iv;
            bit pv;
            longint pe;
            iv = !last_iv && ($urandom_range(0, 1) == 1);
            pv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) < 95) pe = longint'($urandom_range(0, 8190)) - 4095;
            else pe = edge_errs[$urandom_range(0, 5)];
            if ($urandom_range(0, 299) == 0) fm_lvl = !fm_lvl;
            cycle(iv, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768, pv, pe);
            last_iv = iv;
        end
        fm_lvl = 0;
        idle(2);

        // Reset mid-ramp with a sample in flight.
        do_reset();
        for (int i = 0; i < NLOCK; i++) pilot(0);
        for (int i = 0; i < 10; i++) sample(20000, 20000);
        cycle(1, -5000, 7000, 0, 0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_mid_valid", bus.out_valid, 0);
        check_val("rst_mid_left", bus.out_left, 0);
        check_val("rst_mid_right", bus.out_right, 0);
        check_val("rst_mid_blend", bus.blend, 0);
        check_val("rst_mid_stereo", bus.stereo, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_hold_valid", bus.out_valid, 0);
        end
        reset_n = 1'b1;
        idle(3);
        sample(1000, 500);
        check_val("post_rst_left", bus.out_left, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
